branch_resolve: RTL and testbench

Execute-stage branch resolution unit. Accepts one conditional-branch request at a time from decode and drives the operands and condition code to the external combinational condition comparator. It samples the comparator's 1-bit result, computes the branch target and checks it against the decode-stage prediction. On a misprediction it issues a redirect to fetch through a valid/ready handshake.

---
 rtl/branch_pkg.sv | 25 ++
 rtl/branch_stats.sv | 25 ++
 rtl/branch_resolve.sv | 157 +++++++++++++++
 tb/tb_branch_resolve.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolution unit and the
// external condition comparator: condition codes, FSM states, PC increment.
package branch_pkg;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_SGE = 3'b001;
    localparam logic [2:0] CMP_SLE = 3'b010;
    localparam logic [2:0] CMP_SGT = 3'b011;
    localparam logic [2:0] CMP_SLT = 3'b100;
    localparam logic [2:0] CMP_NE  = 3'b101;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        REDIR = 2'd2
    } state_t;

    // Codes 110 and 111 have no comparator meaning.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/branch_stats.sv
// Retired-branch and mispredict event counters; both wrap at 2^32.
module branch_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_branch,
    input  logic        inc_mispredict,
    output logic [31:0] branches,
    output logic [31:0] mispredicts
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches    <= '0;
            mispredicts <= '0;
        end else begin
            if (inc_branch) begin
                branches <= branches + 32'd1;
            end
            if (inc_branch && inc_mispredict) begin
                mispredicts <= mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage conditional branch resolution with redirect handshake to fetch.
// Define BRANCH_STATS_EN to build the retired/mispredict counters.
module branch_resolve
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kill,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_offset,
    input  logic        req_pred_taken,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic [2:0]  cmp_op,
    input  logic        cmp_result,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        resolve_valid,
    output logic        resolve_taken,
    output logic        illegal_op,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] pc_q;
    logic [31:0] offset_q;
    logic        pred_q;
    logic        taken_q;
    logic [31:0] redir_pc_q;
    logic        resolve_valid_q;
    logic        resolve_taken_q;
    logic        illegal_q;

    logic [31:0] fallthrough;
    logic [31:0] target;
    logic        eval_illegal;
    logic        eval_taken;

    // Comparator output is undefined for illegal codes, so it is masked here.
    assign eval_illegal = op_is_illegal(op_q);
    assign eval_taken   = eval_illegal ? 1'b0 : cmp_result;
    assign fallthrough  = pc_q + PC_INCR;
    assign target       = fallthrough + offset_q;

`ifdef BRANCH_STATS_EN
    logic resolve_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolve_mis_q <= 1'b0;
        end else begin
            resolve_mis_q <= !kill && (state == REDIR) && redir_ready;
        end
    end
`endif

    // Handshake: a request transfers when req_valid && req_ready at a rising
    // edge; a redirect transfers when redir_valid && redir_ready. kill wins
    // over both and neither ready depends combinationally on the other side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            op_q            <= CMP_EQ;
            a_q             <= '0;
            b_q             <= '0;
            pc_q            <= RESET_PC;
            offset_q        <= '0;
            pred_q          <= 1'b0;
            taken_q         <= 1'b0;
            redir_pc_q      <= RESET_PC;
            resolve_valid_q <= 1'b0;
            resolve_taken_q <= 1'b0;
            illegal_q       <= 1'b0;
        end else begin
            resolve_valid_q <= 1'b0;
            resolve_taken_q <= 1'b0;
            illegal_q       <= 1'b0;
            if (kill) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            op_q     <= req_op;
                            a_q      <= req_a;
                            b_q      <= req_b;
                            pc_q     <= req_pc;
                            offset_q <= req_offset;
                            pred_q   <= req_pred_taken;
                            state    <= EVAL;
                        end
                    end
                    EVAL: begin
                        taken_q <= eval_taken;
                        if (eval_taken == pred_q) begin
                            resolve_valid_q <= 1'b1;
                            resolve_taken_q <= eval_taken;
                            illegal_q       <= eval_illegal;
                            state           <= IDLE;
                        end else begin
                            redir_pc_q <= eval_taken ? target : fallthrough;
                            state      <= REDIR;
                        end
                    end
                    REDIR: begin
                        if (redir_ready) begin
                            resolve_valid_q <= 1'b1;
                            resolve_taken_q <= taken_q;
                            illegal_q       <= eval_illegal;
                            state           <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready     = (state == IDLE);
    assign redir_valid   = (state == REDIR);
    assign redir_pc      = redir_pc_q;
    assign cmp_a         = a_q;
    assign cmp_b         = b_q;
    assign cmp_op        = op_q;
    assign resolve_valid = resolve_valid_q;
    assign resolve_taken = resolve_taken_q;
    assign illegal_op    = illegal_q;

`ifdef BRANCH_STATS_EN
    branch_stats u_stats (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc_branch     (resolve_valid_q),
        .inc_mispredict (resolve_mis_q),
        .branches       (stat_branches),
        .mispredicts    (stat_mispredicts)
    );
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: transaction-level model with a per-cycle
// compare process, plus hand-computed literal expectations.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kill = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0, req_pc = '0, req_offset = '0;
    logic        req_pred_taken = 1'b0;
    logic [31:0] cmp_a, cmp_b;
    logic [2:0]  cmp_op;
    logic        cmp_result;
    logic        redir_valid;
    logic        redir_ready = 1'b0;
    logic [31:0] redir_pc;
    logic        resolve_valid, resolve_taken, illegal_op;
    logic [31:0] stat_branches, stat_mispredicts;

    logic force_cmp = 1'b0;
    logic force_val = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk(clk), .rst_n(rst_n), .kill(kill),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_offset(req_offset),
        .req_pred_taken(req_pred_taken),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_result(cmp_result),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .illegal_op(illegal_op),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    // Reference condition evaluation from the ISA meaning of each code.
    function automatic logic cond_true(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a == b;
            3'd1: return $signed(a) >= $signed(b);
            3'd2: return $signed(a) <= $signed(b);
            3'd3: return $signed(a) >  $signed(b);
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return a != b;
            default: return 1'b0;
        endcase
    endfunction

    assign cmp_result = force_cmp ? force_val : cond_true(cmp_op, cmp_a, cmp_b);

    // ---------------- model ----------------
    logic        m_busy = 0, m_redirecting = 0;
    logic        m_taken = 0, m_mis = 0, m_illegal = 0, m_last_mis = 0;
    logic [31:0] m_dest = 0;
    logic        exp_req_ready = 1, exp_redir_valid = 0;
    logic [31:0] exp_redir_pc = 32'h0;
    logic        exp_resolve_valid = 0, exp_resolve_taken = 0, exp_illegal = 0;
    logic [31:0] exp_cmp_a = 0, exp_cmp_b = 0;
    logic [2:0]  exp_cmp_op = 0;
    logic [31:0] exp_br = 0, exp_mp = 0;

    task automatic model_reset();
        m_busy = 0; m_redirecting = 0; m_last_mis = 0;
        exp_req_ready = 1; exp_redir_valid = 0; exp_redir_pc = 32'h0;
        exp_resolve_valid = 0; exp_resolve_taken = 0; exp_illegal = 0;
        exp_cmp_a = 0; exp_cmp_b = 0; exp_cmp_op = 0; exp_br = 0; exp_mp = 0;
    endtask

    task automatic model_retire();
        exp_resolve_valid = 1; exp_resolve_taken = m_taken; exp_illegal = m_illegal;
        m_last_mis = m_mis; m_busy = 0; m_redirecting = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (exp_resolve_valid) begin
                exp_br = exp_br + 1;
                if (m_last_mis) exp_mp = exp_mp + 1;
            end
            exp_resolve_valid = 0; exp_resolve_taken = 0; exp_illegal = 0;
            if (kill) begin
                m_busy = 0; m_redirecting = 0;
            end else if (!m_busy) begin
                if (req_valid) begin
                    // Whole outcome decided at accept; forcing is held constant per branch.
                    m_illegal = (req_op == 3'd6) || (req_op == 3'd7);
                    m_taken   = m_illegal ? 1'b0 : (force_cmp ? force_val : cond_true(req_op, req_a, req_b));
                    m_mis     = (m_taken != req_pred_taken);
                    m_dest    = m_taken ? (req_pc + 32'd4 + req_offset) : (req_pc + 32'd4);
                    exp_cmp_a = req_a; exp_cmp_b = req_b; exp_cmp_op = req_op;
                    m_busy = 1; m_redirecting = 0;
                end
            end else if (!m_redirecting) begin
                if (m_mis) begin
                    m_redirecting = 1; exp_redir_pc = m_dest;
                end else begin
                    model_retire();
                end
            end else if (redir_ready) begin
                model_retire();
            end
            exp_req_ready   = !m_busy;
            exp_redir_valid = m_redirecting;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_req_ready});
        chk("redir_valid", {31'd0, redir_valid}, {31'd0, exp_redir_valid});
        chk("redir_pc", redir_pc, exp_redir_pc);
        chk("resolve_valid", {31'd0, resolve_valid}, {31'd0, exp_resolve_valid});
        chk("resolve_taken", {31'd0, resolve_taken}, {31'd0, exp_resolve_taken});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, exp_illegal});
        chk("cmp_a", cmp_a, exp_cmp_a);
        chk("cmp_b", cmp_b, exp_cmp_b);
        chk("cmp_op", {29'd0, cmp_op}, {29'd0, exp_cmp_op});
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, exp_br);
        chk("stat_mispredicts", stat_mispredicts, exp_mp);
`else
        chk("stat_branches", stat_branches, 32'd0);
        chk("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    end

    // ---------------- driver ----------------
    // Called at a negedge; request is presented for exactly one edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off, input logic pred);
        req_op = op; req_a = a; req_b = b; req_pc = pc; req_offset = off;
        req_pred_taken = pred; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, pc, off;
        logic        pred, fc, fv;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h600, 32'h10, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{3'd2, 32'd5, 32'hFFFF_FFFF, 32'h610, 32'h30, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h620, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{3'd4, 32'd2, 32'd3, 32'h630, 32'h8, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3'd5, 32'd4, 32'd4, 32'h640, 32'h8, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{3'd6, 32'd1, 32'd1, 32'h650, 32'h8, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{3'd0, 32'd7, 32'd8, 32'h660, 32'h40, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Correct-predicted eq, then a back-to-back request at the resolve cycle.
        send(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
        chk("t1_cmp_a", cmp_a, 32'd5);
        chk("t1_ready_eval", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("t1_resolve_valid", {31'd0, resolve_valid}, 32'd1);
        chk("t1_resolve_taken", {31'd0, resolve_taken}, 32'd1);
        chk("t1_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("t1_ready_again", {31'd0, req_ready}, 32'd1);
        send(3'd0, 32'd9, 32'd9, 32'h120, 32'h4, 1'b1);
        chk("t1b_accepted", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("t1b_resolve_valid", {31'd0, resolve_valid}, 32'd1);

        // Mispredicted slt with 3 cycles of fetch backpressure.
        redir_ready = 0;
        send(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0);
        @(negedge clk);
        chk("t2_redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("t2_redir_pc", redir_pc, 32'h244);
        repeat (3) @(negedge clk);
        chk("t2_redir_held", {31'd0, redir_valid}, 32'd1);
        redir_ready = 1;
        @(negedge clk);
        redir_ready = 0;
        chk("t2_resolve_valid", {31'd0, resolve_valid}, 32'd1);
        chk("t2_resolve_taken", {31'd0, resolve_taken}, 32'd1);
        chk("t2_redir_dropped", {31'd0, redir_valid}, 32'd0);
        @(negedge clk);
`ifdef BRANCH_STATS_EN
        chk("t2_stat_mispredicts", stat_mispredicts, 32'd1);
`else
        chk("t2_stat_mispredicts", stat_mispredicts, 32'd0);
`endif

        // Target wraps past 2^32.
        redir_ready = 1;
        send(3'd5, 32'd1, 32'd2, 32'hFFFF_FFF8, 32'h10, 1'b0);
        @(negedge clk);
        chk("t3_redir_pc_wrap", redir_pc, 32'h0000_000C);
        @(negedge clk);
        chk("t3_resolve_valid", {31'd0, resolve_valid}, 32'd1);

        // Illegal op with comparator stuck at 1 resolves not-taken.
        force_cmp = 1; force_val = 1;
        send(3'd7, 32'd3, 32'd9, 32'h300, 32'h80, 1'b1);
        @(negedge clk);
        chk("t4_redir_pc", redir_pc, 32'h304);
        @(negedge clk);
        force_cmp = 0; force_val = 0;
        chk("t4_resolve_valid", {31'd0, resolve_valid}, 32'd1);
        chk("t4_resolve_taken", {31'd0, resolve_taken}, 32'd0);
        chk("t4_illegal_op", {31'd0, illegal_op}, 32'd1);

        // kill in REDIR beats a simultaneous handshake.
        redir_ready = 0;
        send(3'd0, 32'd1, 32'd2, 32'h400, 32'h8, 1'b1);
        @(negedge clk);
        chk("t5_in_redir", {31'd0, redir_valid}, 32'd1);
        kill = 1; redir_ready = 1;
        @(negedge clk);
        kill = 0; redir_ready = 0;
        chk("t5_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("t5_no_resolve", {31'd0, resolve_valid}, 32'd0);
        chk("t5_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        chk("t5_no_resolve_late", {31'd0, resolve_valid}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("t5_stat_branches", stat_branches, 32'd5);
`else
        chk("t5_stat_branches", stat_branches, 32'd0);
`endif

        // kill during EVAL, and kill on an accept edge.
        send(3'd0, 32'd3, 32'd3, 32'h480, 32'h8, 1'b1);
        kill = 1;
        @(negedge clk);
        kill = 0;
        chk("t6_eval_killed", {31'd0, resolve_valid}, 32'd0);
        kill = 1;
        send(3'd0, 32'd3, 32'd3, 32'h490, 32'h8, 1'b1);
        kill = 0;
        chk("t6_accept_killed", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // Mixed directed vectors through the model.
        redir_ready = 1;
        foreach (vecs[i]) begin
            force_cmp = vecs[i].fc; force_val = vecs[i].fv;
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].off, vecs[i].pred);
            repeat (3) @(negedge clk);
        end
        force_cmp = 0; force_val = 0;
        redir_ready = 0;

        // Asynchronous reset in the middle of EVAL.
        send(3'd0, 32'hAB, 32'hAB, 32'h500, 32'h8, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("t7_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t7_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("t7_redir_pc", redir_pc, 32'h0);
        chk("t7_cmp_a", cmp_a, 32'd0);
        chk("t7_cmp_op", {29'd0, cmp_op}, 32'd0);
        chk("t7_resolve_valid", {31'd0, resolve_valid}, 32'd0);
        chk("t7_stat_branches", stat_branches, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        send(3'd3, 32'd10, 32'd2, 32'h700, 32'h8, 1'b1);
        @(negedge clk);
        chk("t7_recover_resolve", {31'd0, resolve_valid}, 32'd1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
